// File: rtl/spi_status_pkg.sv
// spi_status_pkg: shared constants and FSM state type for the SPI status transmitter.
package spi_status_pkg;
    localparam int DEFAULT_WORD_BITS = 16;
    localparam int FRAME_BITS = 2 * DEFAULT_WORD_BITS;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronises an asynchronous pin and derives single-cycle edge strobes.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic hist;
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end
    assign o_level = sync[SYNC_STAGES-1];
    assign o_rise = o_level & ~hist;
    assign o_fall = ~o_level & hist;
endmodule

// File: rtl/spi_status_tx.sv
// spi_status_tx: SPI mode-0 slave that shifts a two-word status frame out on MISO per chip-select.
module spi_status_tx
    import spi_status_pkg::*;
#(
    parameter int WORD_BITS = DEFAULT_WORD_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 fpga_clock,
    input  logic                 reset,
    input  logic                 i_SPI_CS,
    input  logic                 i_SPI_clock,
    input  logic [WORD_BITS-1:0] i_data0,
    input  logic [WORD_BITS-1:0] i_data1,
    input  logic                 i_load,
    output logic                 o_SPI_data,
    output logic                 o_SPI_data_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_aborted
);
    localparam int NBITS = 2 * WORD_BITS;
    localparam int CW = $clog2(NBITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    logic cs_level, cs_rise, cs_fall, sck_level, sck_rise, sck_fall;
    logic unused_levels;
    state_t state, state_next;
    logic [NBITS-1:0] holding, shift;
    logic [CW-1:0] count;
    logic done_q, aborted_q, last_rise;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clock(fpga_clock), .reset(reset), .async_in(i_SPI_CS),
        .o_level(cs_level), .o_rise(cs_rise), .o_fall(cs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clock(fpga_clock), .reset(reset), .async_in(i_SPI_clock),
        .o_level(sck_level), .o_rise(sck_rise), .o_fall(sck_fall)
    );
    assign unused_levels = cs_level ^ sck_level;

    // cs_rise outranks any SCK edge landing in the same cycle
    assign last_rise = state == ST_SHIFT && !cs_rise && sck_rise && count == LAST;

    always_ff @(posedge fpga_clock) begin
        state <= reset ? ST_IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = cs_fall ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_next = cs_rise ? ST_IDLE : last_rise ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_next = cs_rise ? ST_IDLE : ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Frame snapshots the pre-load holding value when i_load coincides with cs_fall
    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            holding <= '0;
            shift <= '0;
            count <= '0;
            done_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            if (i_load)
                holding <= {i_data0, i_data1};
            done_q <= last_rise;
            aborted_q <= state == ST_SHIFT && cs_rise;
            if (state == ST_IDLE && cs_fall) begin
                shift <= holding;
                count <= '0;
            end else if (state == ST_SHIFT && !cs_rise) begin
                if (sck_rise)
                    count <= count + CW'(1);
                if (sck_fall)
                    shift <= {shift[NBITS-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        o_busy = state != ST_IDLE;
        o_SPI_data_en = state != ST_IDLE;
        o_SPI_data = state == ST_SHIFT ? shift[NBITS-1] : 1'b0;
        o_done = done_q;
        o_aborted = aborted_q;
    end
endmodule

// File: tb/tb_spi_status_tx.sv
// tb_spi_status_tx: directed frame vectors plus reset and idle-SCK sequences for spi_status_tx.
module tb_spi_status_tx;
    logic clk = 1'b0, reset, cs, sck, load, miso, en, busy, done, aborted;
    logic [15:0] d0, d1;
    int total = 0, bad = 0, n_done = 0, n_abort = 0;

    typedef struct {
        bit load;
        bit fall_load;
        logic [15:0] d0;
        logic [15:0] d1;
        int nbits;
        logic [63:0] exp_bits;
        int exp_done;
        int exp_abort;
    } vec_t;
    vec_t vecs[8];

    spi_status_tx dut (
        .fpga_clock(clk), .reset(reset), .i_SPI_CS(cs), .i_SPI_clock(sck),
        .i_data0(d0), .i_data1(d1), .i_load(load),
        .o_SPI_data(miso), .o_SPI_data_en(en), .o_busy(busy),
        .o_done(done), .o_aborted(aborted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) n_done++;
        if (aborted) n_abort++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input bit fall_load, input int nbits, output logic [63:0] got, output logic [1:0] en_mid);
        got = '0;
        en_mid = '0;
        cs = 1'b0;
        repeat (2) @(negedge clk);
        load = fall_load;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            if (b == 0) en_mid = {busy, en};
            got = {got[62:0], miso};
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [63:0] got;
        logic [1:0] en_mid;
        logic any;
        int sd, sa;
        vecs[0] = '{1'b1, 1'b0, 16'hA55A, 16'h1234, 32, 64'hA55A1234, 1, 0};
        vecs[1] = '{1'b1, 1'b0, 16'hA55A, 16'h1234, 10, 64'h295, 0, 1};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 32, 64'hA55A1234, 1, 0};
        vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 32, 64'hA55A1234, 1, 0};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 32, 64'hFFFF0000, 1, 0};
        vecs[5] = '{1'b1, 1'b0, 16'h8001, 16'h8001, 40, 64'h8001800100, 1, 0};
        vecs[6] = '{1'b1, 1'b0, 16'h1234, 16'h5678, 16, 64'h1234, 0, 1};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 32, 64'h12345678, 1, 0};
        reset = 1'b1; cs = 1'b1; sck = 1'b0; load = 1'b0; d0 = '0; d1 = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({miso, en, busy, done, aborted}), 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            d0 = vecs[i].d0;
            d1 = vecs[i].d1;
            if (vecs[i].load) begin
                load = 1'b1;
                @(negedge clk);
                load = 1'b0;
                @(negedge clk);
            end
            sd = n_done;
            sa = n_abort;
            run_frame(vecs[i].fall_load, vecs[i].nbits, got, en_mid);
            check($sformatf("v%0d bits", i), got, vecs[i].exp_bits);
            check($sformatf("v%0d done", i), 64'(n_done - sd), 64'(vecs[i].exp_done));
            check($sformatf("v%0d abort", i), 64'(n_abort - sa), 64'(vecs[i].exp_abort));
            check($sformatf("v%0d busy_en_mid", i), 64'(en_mid), 64'd3);
            check($sformatf("v%0d busy_en_after", i), 64'({busy, en}), 64'd0);
        end

        // reset during bit 17 of a frame
        cs = 1'b0;
        repeat (6) @(negedge clk);
        repeat (16) begin
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        sck = 1'b1;
        @(negedge clk);
        check("busy before reset", 64'(busy), 64'd1);
        sa = n_abort;
        reset = 1'b1;
        @(negedge clk);
        check("outputs after mid reset", 64'({miso, en, busy, done, aborted}), 64'd0);
        repeat (3) @(negedge clk);
        sck = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        check("no abort on reset", 64'(n_abort - sa), 64'd0);
        sd = n_done;
        run_frame(1'b0, 32, got, en_mid);
        check("frame after reset", got, 64'd0);
        check("done after reset", 64'(n_done - sd), 64'd1);

        // SCK toggling with CS high must be ignored
        sd = n_done;
        sa = n_abort;
        any = 1'b0;
        repeat (8) begin
            sck = 1'b1;
            repeat (4) begin @(negedge clk); any = any | miso | en | busy; end
            sck = 1'b0;
            repeat (4) begin @(negedge clk); any = any | miso | en | busy; end
        end
        check("idle sck outputs", 64'(any), 64'd0);
        check("idle sck pulses", 64'((n_done - sd) + (n_abort - sa)), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_status_tx.md
# spi_status_tx

SPI slave transmitter returning a two-word status frame from the FPGA to the control microcontroller. It shares the microcontroller's SPI chip-select and clock with the inbound receiver and drives data back on MISO. Both pins are oversampled in the `fpga_clock` domain. The synth core loads status words (for example current frequency and debug sample) into a holding register. Each chip-select assertion shifts one frame out MSB first, SPI mode 0.

## Interface
Parameters:
- WORD_BITS, 16, width of each status word
- SYNC_STAGES, 2, synchroniser flops on SPI clock and chip-select (min 2)

Ports:
- fpga_clock  in  1  system clock, 72 MHz
- reset  in  1  reset reset, synchronous, active-high; clock fpga_clock
- i_SPI_CS  in  1  chip-select from MCU, active-low, asynchronous
- i_SPI_clock  in  1  SPI clock from MCU, idles low, asynchronous
- i_data0  in  WORD_BITS  first word, sent first
- i_data1  in  WORD_BITS  second word
- i_load  in  1  one-cycle strobe, captures i_data0/i_data1 into holding register
- o_SPI_data  out  1  MISO data
- o_SPI_data_en  out  1  MISO output enable, high only while a frame is selected
- o_busy  out  1  frame in progress (CS low seen, not yet released)
- o_done  out  1  one-cycle pulse when the full 2*WORD_BITS bits have been clocked
- o_aborted  out  1  one-cycle pulse when CS rises before the frame completes

## Operation
- The synchroniser registers CS and SCK through SYNC_STAGES flops, plus one history flop for edge detection. This gives cs_fall, cs_rise, sck_rise and sck_fall as single-cycle strobes.
- Holding register: 2*WORD_BITS, {i_data0, i_data1}. It is written on i_load in any state and resets to 0.
- States:
  - IDLE: outputs quiet. On cs_fall, copy the holding register to the shift register, clear the bit counter and go to SHIFT.
  - SHIFT: o_SPI_data = shift[MSB].
    - sck_rise: increment the bit counter. When it reaches 2*WORD_BITS, pulse o_done and go to DONE.
    - sck_fall: shift left, filling with 0.
  - DONE: o_SPI_data = 0. Wait for cs_rise, then go to IDLE.
- A cs_rise while in SHIFT pulses o_aborted and returns to IDLE. The shift register is discarded and the holding register is untouched.
- cs_rise takes priority over any SCK edge detected in the same cycle.
- i_load in the same cycle as cs_fall updates the holding register only. The frame uses the pre-load value, and the new value goes out in the next frame.
- SCK edges while in IDLE or DONE are ignored.
- Bits clocked beyond 2*WORD_BITS are 0.
- Bit counter width: clog2(2*WORD_BITS)+1. It does not wrap within a frame.

## Timing
- Reset values (all outputs): o_SPI_data=0, o_SPI_data_en=0, o_busy=0, o_done=0, o_aborted=0, state IDLE, holding=0, shift=0, counter=0.
- Reset mid-frame: everything returns to IDLE on the next clock and no o_aborted is pulsed. The MCU's partial frame is undefined.
- Pin-to-strobe latency: SYNC_STAGES+1 fpga_clock cycles.
- The first data bit is valid SYNC_STAGES+2 cycles after the CS pin falls. The MCU must allow at least this CS-to-first-SCK setup: 56 ns at 72 MHz with the default parameters.
- o_SPI_data updates SYNC_STAGES+2 cycles after each SCK pin falling edge. Maximum SCK = fpga_clock/8 (9 MHz) so that data settles before the next rising edge.
- o_SPI_data_en and o_busy rise in the cycle after cs_fall and fall in the cycle after cs_rise.
- o_done asserts in the cycle after the final sck_rise. o_busy stays high until cs_rise.

## Structure
- Shared package spi_status_pkg:
  - WORD_BITS default
  - FRAME_BITS = 2*WORD_BITS
  - state enum {ST_IDLE, ST_SHIFT, ST_DONE}
- Sub-module spi_sync_edge (parameter SYNC_STAGES; ports clock, reset, async_in, o_level, o_rise, o_fall), instantiated once for CS and once for SCK.
- The top level holds the holding register, shift register, counter and FSM. Tristate buffering is done at the pad from o_SPI_data_en.

## Test plan
- Load 0xA55A/0x1234, assert CS, clock 32 mode-0 bits at 9 MHz. Sampled MISO must equal 0xA55A1234 MSB first. o_done pulses once after bit 32, and o_busy drops after CS rises.
- Assert CS, clock 10 bits, release CS. o_aborted pulses once and no o_done. The next full frame resends the same words from bit 0.
- Hold the load at 0xA55A/0x1234, then pulse i_load with 0xFFFF/0x0000 in the exact cs_fall strobe cycle. The current frame reads 0xA55A1234 and the following frame reads 0xFFFF0000.
- Clock 40 bits in one frame with 0x8001/0x8001 loaded. The first 32 bits are 0x80018001, bits 33–40 are 0, and o_done pulses exactly once.
- Assert reset at bit 17 of a frame. All outputs are 0 on the next clock with no o_aborted. After release, a new CS frame sends 0x00000000 because the holding register was cleared.
- Toggle SCK 8 times with CS high. MISO, o_SPI_data_en and o_busy stay 0 and no pulses occur.
